// File: rtl/mag_cal_if.sv
// Magnetometer sample/offset/calibration-status bundle between sensor wrapper, calibrator and heading logic.
// master drives commands and raw samples; slave (the calibrator) drives corrected samples and status.
interface mag_cal_if;
  logic               cal_start;
  logic               cal_abort;
  logic               sample_valid;
  logic signed [15:0] mag_x_in;
  logic signed [15:0] mag_y_in;
  logic signed [15:0] mag_x_out;
  logic signed [15:0] mag_y_out;
  logic               out_valid;
  logic signed [15:0] offset_x;
  logic signed [15:0] offset_y;
  logic               cal_busy;
  logic               cal_done;
  logic               cal_fail;
  logic               cal_ok;

  modport master (
    output cal_start, cal_abort, sample_valid, mag_x_in, mag_y_in,
    input  mag_x_out, mag_y_out, out_valid, offset_x, offset_y,
    input  cal_busy, cal_done, cal_fail, cal_ok
  );

  modport slave (
    input  cal_start, cal_abort, sample_valid, mag_x_in, mag_y_in,
    output mag_x_out, mag_y_out, out_valid, offset_x, offset_y,
    output cal_busy, cal_done, cal_fail, cal_ok
  );
endinterface

// File: rtl/mag_cal_controller.sv
// Hard-iron calibration: min/max sweep -> centre offsets, subtracted (saturating) from every sample.
// Correction latency 1 cycle; no backpressure, every sample_valid strobe produces one out_valid strobe.
module mag_cal_controller #(
  parameter int SAMPLE_COUNT = 1024,
  parameter int MIN_SPAN     = 64
) (
  input logic      clk,
  input logic      reset_n,
  mag_cal_if.slave bus
);
  localparam int                 CW         = $clog2(SAMPLE_COUNT + 1);
  localparam logic [CW-1:0]      LAST_IDX   = CW'(SAMPLE_COUNT - 1);
  localparam logic signed [16:0] MIN_SPAN_S = 17'(MIN_SPAN);

  typedef enum logic [1:0] {IDLE, SWEEP, COMPUTE} state_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } xy_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  xy_t           min_q, min_d;
  xy_t           max_q, max_d;
  xy_t           off_q, off_d;
  xy_t           out_q, out_d;
  logic          out_vld_q, out_vld_d;
  logic          ok_q, ok_d;
  logic          done_q, done_d;
  logic          fail_q, fail_d;
  logic          busy_q, busy_d;

  xy_t                smp;
  logic signed [16:0] span_x, span_y;
  logic signed [16:0] sum_x, sum_y;
  logic               span_ok;

  function automatic logic signed [15:0] correct(input logic signed [15:0] v,
                                                 input logic signed [15:0] o);
    logic signed [16:0] d;
    d = {v[15], v} - {o[15], o};
    if (d[16] != d[15]) begin
      correct = d[16] ? 16'sh8000 : 16'sh7fff;
    end else begin
      correct = d[15:0];
    end
  endfunction

  assign smp = {bus.mag_x_in, bus.mag_y_in};

  // Spans are never negative once the first sample has seeded min and max.
  assign span_x  = {max_q.x[15], max_q.x} - {min_q.x[15], min_q.x};
  assign span_y  = {max_q.y[15], max_q.y} - {min_q.y[15], min_q.y};
  assign sum_x   = {max_q.x[15], max_q.x} + {min_q.x[15], min_q.x};
  assign sum_y   = {max_q.y[15], max_q.y} + {min_q.y[15], min_q.y};
  assign span_ok = (span_x >= MIN_SPAN_S) && (span_y >= MIN_SPAN_S);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    min_d     = min_q;
    max_d     = max_q;
    off_d     = off_q;
    ok_d      = ok_q;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    out_d     = out_q;
    out_vld_d = bus.sample_valid;

    // Correction always uses the offsets currently held, whatever the FSM state.
    if (bus.sample_valid) begin
      out_d.x = correct(smp.x, off_q.x);
      out_d.y = correct(smp.y, off_q.y);
    end

    case (state_q)
      IDLE: begin
        if (bus.cal_start && !bus.cal_abort) begin
          state_d = SWEEP;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      SWEEP: begin
        if (bus.cal_abort) begin
          state_d = IDLE;
        end else if (bus.sample_valid) begin
          first_d = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          if (first_q) begin
            min_d = smp;
            max_d = smp;
          end else begin
            if (smp.x < min_q.x) min_d.x = smp.x;
            if (smp.x > max_q.x) max_d.x = smp.x;
            if (smp.y < min_q.y) min_d.y = smp.y;
            if (smp.y > max_q.y) max_d.y = smp.y;
          end
          if (cnt_q == LAST_IDX) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        state_d = IDLE;
        // Bits [16:1] of the 17-bit sum are the floored arithmetic half.
        if (span_ok) begin
          off_d.x = sum_x[16:1];
          off_d.y = sum_y[16:1];
          ok_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          fail_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      min_q     <= '0;
      max_q     <= '0;
      off_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      ok_q      <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      min_q     <= min_d;
      max_q     <= max_d;
      off_q     <= off_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      ok_q      <= ok_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.mag_x_out = out_q.x;
  assign bus.mag_y_out = out_q.y;
  assign bus.out_valid = out_vld_q;
  assign bus.offset_x  = off_q.x;
  assign bus.offset_y  = off_q.y;
  assign bus.cal_busy  = busy_q;
  assign bus.cal_done  = done_q;
  assign bus.cal_fail  = fail_q;
  assign bus.cal_ok    = ok_q;
endmodule

// File: tb/tb_mag_cal_controller.sv
// Directed + randomized bench for mag_cal_controller against a min/max/centre reference model.
module tb_mag_cal_controller;
  localparam int SC = 4;
  localparam int MS = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mag_cal_if bus();

  mag_cal_controller #(.SAMPLE_COUNT(SC), .MIN_SPAN(MS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_off_x = 0;
  int m_off_y = 0;
  int m_ok = 0;
  int sx[SC];
  int sy[SC];

  task automatic chk(input string tag, input string what,
                     input logic signed [31:0] obs, input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int floor_half(input int v);
    return (v - ((v < 0) ? 1 : 0)) / 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input int busy, input int done, input int fail);
    chk(tag, "busy", bus.cal_busy, busy);
    chk(tag, "done", bus.cal_done, done);
    chk(tag, "fail", bus.cal_fail, fail);
    chk(tag, "off_x", bus.offset_x, m_off_x);
    chk(tag, "off_y", bus.offset_y, m_off_y);
    chk(tag, "ok", bus.cal_ok, m_ok);
  endtask

  task automatic send(input string tag, input int x, input int y);
    bus.sample_valid = 1'b1;
    bus.mag_x_in = 16'(x);
    bus.mag_y_in = 16'(y);
    step();
    bus.sample_valid = 1'b0;
    chk(tag, "out_valid", bus.out_valid, 1);
    chk(tag, "out_x", bus.mag_x_out, sat(x - m_off_x));
    chk(tag, "out_y", bus.mag_y_out, sat(y - m_off_y));
  endtask

  // One calibration sweep over sx/sy; optionally aborted at sample abort_at,
  // with a stray cal_start during the sweep, or with reset in the COMPUTE cycle.
  task automatic sweep(input string tag, input int abort_at, input bit abort_w_smp,
                       input bit mid_start, input bit rst_compute);
    int mnx, mxx, mny, mxy;
    bit pass;
    bus.cal_start = 1'b1;
    step();
    bus.cal_start = 1'b0;
    chk(tag, "busy_go", bus.cal_busy, 1);
    for (int i = 0; i < SC; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        step();
        check_status(tag, 1, 0, 0);
      end
      if (i == abort_at) begin
        bus.cal_abort = 1'b1;
        if (abort_w_smp) send(tag, sx[i], sy[i]);
        else step();
        bus.cal_abort = 1'b0;
        check_status(tag, 0, 0, 0);
        step();
        check_status(tag, 0, 0, 0);
        return;
      end
      if (mid_start && i == 1) bus.cal_start = 1'b1;
      send(tag, sx[i], sy[i]);
      bus.cal_start = 1'b0;
      check_status(tag, 1, 0, 0);
    end
    mnx = sx[0]; mxx = sx[0]; mny = sy[0]; mxy = sy[0];
    for (int i = 1; i < SC; i++) begin
      if (sx[i] < mnx) mnx = sx[i];
      if (sx[i] > mxx) mxx = sx[i];
      if (sy[i] < mny) mny = sy[i];
      if (sy[i] > mxy) mxy = sy[i];
    end
    pass = (mxx - mnx >= MS) && (mxy - mny >= MS);
    if (rst_compute) begin
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      m_off_x = 0; m_off_y = 0; m_ok = 0;
      check_status(tag, 0, 0, 0);
      chk(tag, "rst_out_valid", bus.out_valid, 0);
      return;
    end
    // A sample in the COMPUTE cycle still sees the old offsets.
    if ($urandom_range(0, 1) == 1) send(tag, $urandom_range(0, 4000) - 2000, $urandom_range(0, 4000) - 2000);
    else step();
    if (pass) begin
      m_off_x = floor_half(mxx + mnx);
      m_off_y = floor_half(mxy + mny);
      m_ok = 1;
    end
    check_status(tag, 0, pass ? 1 : 0, pass ? 0 : 1);
    step();
    check_status(tag, 0, 0, 0);
  endtask

  initial begin
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    bus.sample_valid = 1'b0;
    bus.mag_x_in = '0;
    bus.mag_y_in = '0;

    // Reset with random inputs
    reset_n = 1'b0;
    repeat (3) begin
      bus.mag_x_in = 16'($urandom);
      bus.mag_y_in = 16'($urandom);
      bus.sample_valid = 1'($urandom_range(0, 1));
      bus.cal_start = 1'($urandom_range(0, 1));
      bus.cal_abort = 1'($urandom_range(0, 1));
      step();
    end
    chk("reset", "out_x", bus.mag_x_out, 0);
    chk("reset", "out_y", bus.mag_y_out, 0);
    chk("reset", "out_valid", bus.out_valid, 0);
    check_status("reset", 0, 0, 0);
    bus.sample_valid = 1'b0;
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    reset_n = 1'b1;
    step();

    // Accepted sweep
    sx = '{100, -20, 300, 40};
    sy = '{-50, 150, 10, -250};
    sweep("accept", -1, 0, 0, 0);
    chk("accept", "off_x_const", bus.offset_x, 140);
    chk("accept", "off_y_const", bus.offset_y, -50);
    chk("accept", "ok_const", bus.cal_ok, 1);
    send("follow", 200, 0);
    chk("follow", "x_const", bus.mag_x_out, 60);
    chk("follow", "y_const", bus.mag_y_out, 50);
    step();
    chk("hold", "out_valid", bus.out_valid, 0);
    chk("hold", "out_x", bus.mag_x_out, 60);

    // Rejected sweep: x span 30
    sx = '{10, 20, 30, 40};
    sy = '{-200, 200, 0, 5};
    sweep("reject", -1, 0, 0, 0);
    chk("reject", "off_x_const", bus.offset_x, 140);
    chk("reject", "ok_const", bus.cal_ok, 1);

    // Saturation at both rails
    send("sat", -32768, 32767);
    chk("sat", "x_const", bus.mag_x_out, -32768);
    chk("sat", "y_const", bus.mag_y_out, 32767);

    // Abort after two samples, then a full fresh sweep
    sx = '{5000, -5000, 7, 9};
    sy = '{4000, -4000, 1, 2};
    sweep("abort2", 2, 0, 0, 0);
    sx = '{-1000, 1000, -300, 501};
    sy = '{-31000, -30000, -30500, -30999};
    sweep("restart", -1, 0, 0, 0);

    // Abort wins over a simultaneous final sample
    sx = '{-20000, 20000, 0, 1};
    sy = '{-20000, 20000, 0, 1};
    sweep("abort_final", SC - 1, 1, 0, 0);

    // Idle start+abort together stays idle
    bus.cal_start = 1'b1;
    bus.cal_abort = 1'b1;
    step();
    bus.cal_start = 1'b0;
    bus.cal_abort = 1'b0;
    check_status("start_abort", 0, 0, 0);

    // Stray cal_start mid-sweep, then reset during COMPUTE
    sx = '{-3, 300, 0, 77};
    sy = '{-500, 0, 99, -1};
    sweep("mid_start", -1, 0, 1, 0);
    sweep("rst_compute", -1, 0, 0, 1);

    // Randomized sweeps interleaved with full-range correction samples
    for (int n = 0; n < 30; n++) begin
      int bx, by, rx, ry;
      bx = $urandom_range(0, 60000) - 30000;
      by = $urandom_range(0, 60000) - 30000;
      rx = $urandom_range(10, 300);
      ry = $urandom_range(10, 300);
      for (int i = 0; i < SC; i++) begin
        sx[i] = bx + $urandom_range(0, rx) - rx / 2;
        sy[i] = by + $urandom_range(0, ry) - ry / 2;
      end
      sweep("rand", -1, 0, ($urandom_range(0, 3) == 0), 0);
      repeat ($urandom_range(1, 3)) send("rand_corr", $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
